mmio_bridge: RTL and testbench
==============================

// Module: mmio_bridge
// PURPOSE
//  Memory-mapped I/O bridge on the CPU data path, downstream of the ALU address
//  and decoder store data, beside Data_mem. Decodes each load/store address:
//  I/O hits go to the LED register, the debounced switch port or a free-running
//  timer; all other addresses pass to Data_mem. Returns the selected read data
//  to the decoder write-back mux. It replaces the direct switch/led wiring of
//  the top level.
// PARAMETERS
//  IO_BASE          32'hFFFF_FC00  I/O window base; the window is 1 KiB, [9:0] offset
//  DEBOUNCE_CYCLES  20000          stable cycles required before a switch bit updates
//  SW_WIDTH         8              number of switch inputs
//  LED_WIDTH        8              number of LED outputs
// PORTS
//  clk            in   1   system clock; all state updates on rising edge
//  rst            in   1   asynchronous, active-high reset
//  addr           in   32  byte address from ALU_result
//  mem_read       in   1   load in this cycle
//  mem_write      in   1   store in this cycle
//  write_data     in   32  store data (decoder read_data_2)
//  dmem_rdata     in   32  Data_mem ReadData
//  dmem_write     out  1   gated MemWrite to Data_mem (mem_write & ~io_hit)
//  read_data      out  32  load data to write-back mux
//  switch_in      in   SW_WIDTH   raw board switches, asynchronous
//  led            out  LED_WIDTH  LED register
// BEHAVIOUR
//  - io_hit = (addr[31:10] == IO_BASE[31:10]). Offsets: 0x060 LED (R/W),
//    0x070 SWITCH (R), 0x074 SW_EVENT (R, clear-on-read), 0x080 TIMER (R/W).
//    Unmapped I/O offset: store ignored, load returns 32'h0.
//  - Reset: led=0, timer=0, sync FFs=0, stable switches=0, debounce counters=0,
//    sw_event=0. dmem_write and read_data are combinational and follow inputs.
//  - read_data is combinational, same cycle as addr: io_hit ? io_mux : dmem_rdata.
//    SWITCH returns {zeros, stable[SW_WIDTH-1:0]}. LED returns {zeros, led}.
//  - Store to LED: led <= write_data[LED_WIDTH-1:0] at the next edge. Higher bits
//    are dropped.
//  - Switch path per bit: 2-FF synchronizer -> sync. If sync != stable, the
//    counter increments. Otherwise the counter clears. When the counter reaches
//    DEBOUNCE_CYCLES-1 with sync still != stable: stable <= sync, counter <= 0.
//    A glitch shorter than DEBOUNCE_CYCLES never changes stable. Latency from a
//    clean edge to stable is 2 + DEBOUNCE_CYCLES cycles.
//  - sw_event[i] is sticky. It sets on every update of stable[i]. A load
//    (mem_read) of SW_EVENT returns the current value and clears it at the edge.
//    If set and clear happen in the same cycle, set wins (the new event is kept).
//  - Timer increments every cycle and wraps 32'hFFFF_FFFF -> 0. A store to TIMER
//    loads write_data; the next cycle shows write_data+1. The store has priority
//    over the increment.
//  - mem_read and mem_write asserted together: the store applies and the load
//    returns the pre-edge value.
//  - rst asserted mid-debounce or mid-store: all state returns to reset values
//    immediately. No write completes.
//  - Counter width is $clog2(DEBOUNCE_CYCLES). DEBOUNCE_CYCLES=1 is legal (update
//    after the synchronizer only).
// STRUCTURE
//  - Shared package/include (definitions.v): IO_BASE, the offset constants
//    (IO_LED_OFF, IO_SW_OFF, IO_SWEV_OFF, IO_TMR_OFF) and ISA_WIDTH.
//  - One sub-module: switch_debouncer (param DEBOUNCE_CYCLES, 1 bit; clk, rst,
//    raw, stable, changed). It is instantiated SW_WIDTH times with generate.
//    Decode, LED, timer and read mux stay inline.
// TESTING
//  1 Reset: assert rst mid-run -> led=0, timer reads 0 the cycle after release,
//    and SWITCH reads 0.
//  2 Store 32'h0000_01A5 to FFFF_FC60 -> led=8'hA5 next edge; dmem_write=0;
//    load from FC60 returns 32'hA5.
//  3 DEBOUNCE_CYCLES=4: switch_in 00->3C held -> SWITCH reads 3C exactly 6 cycles
//    later and SW_EVENT=3C. A 3-cycle pulse on bit0 -> no change, no event.
//  4 Load SW_EVENT returns 3C; the next load returns 0. A new stable update in
//    the same cycle as the clearing load -> that bit stays set.
//  5 Store FFFF_FFFE to FC80 -> reads FFFF_FFFF, then 0 (wrap).
//  6 Store/load at 0x0000_0010 -> dmem_write=1, read_data=dmem_rdata. Load at
//    unmapped FFFF_FC90 -> 0, no state change.

Source files
------------

// File: rtl/mmio_bridge_pkg.sv
// rtl/mmio_bridge_pkg.sv - shared I/O window constants and offset decode for mmio_bridge
package mmio_bridge_pkg;

  localparam int          ISA_WIDTH   = 32;
  localparam logic [31:0] IO_BASE     = 32'hFFFF_FC00;
  localparam logic [9:0]  IO_LED_OFF  = 10'h060;
  localparam logic [9:0]  IO_SW_OFF   = 10'h070;
  localparam logic [9:0]  IO_SWEV_OFF = 10'h074;
  localparam logic [9:0]  IO_TMR_OFF  = 10'h080;

  typedef enum logic [2:0] {
    IO_SEL_NONE,
    IO_SEL_LED,
    IO_SEL_SW,
    IO_SEL_SWEV,
    IO_SEL_TMR
  } io_sel_e;

  function automatic io_sel_e decode_offset(input logic [9:0] off);
    io_sel_e sel;
    case (off)
      IO_LED_OFF:  sel = IO_SEL_LED;
      IO_SW_OFF:   sel = IO_SEL_SW;
      IO_SWEV_OFF: sel = IO_SEL_SWEV;
      IO_TMR_OFF:  sel = IO_SEL_TMR;
      default:     sel = IO_SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - one-bit 2-FF synchronizer plus stability counter
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic changed
);
  import mmio_bridge_pkg::*;

  // A width of at least one bit keeps DEBOUNCE_CYCLES=1 legal; the counter then sits at 0.
  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  assign changed = (sync != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == stable) begin
        cnt <= '0;
      end else if (changed) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - load/store address decode between the CPU data path, Data_mem and board I/O
module mmio_bridge #(
  parameter logic [31:0] IO_BASE         = mmio_bridge_pkg::IO_BASE,
  parameter int          DEBOUNCE_CYCLES = 20000,
  parameter int          SW_WIDTH        = 8,
  parameter int          LED_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          addr,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          write_data,
  input  logic [31:0]          dmem_rdata,
  output logic                 dmem_write,
  output logic [31:0]          read_data,
  input  logic [SW_WIDTH-1:0]  switch_in,
  output logic [LED_WIDTH-1:0] led
);
  import mmio_bridge_pkg::*;

  logic                io_hit;
  io_sel_e             io_sel;
  logic [SW_WIDTH-1:0] sw_stable;
  logic [SW_WIDTH-1:0] sw_changed;
  logic [SW_WIDTH-1:0] sw_event;
  logic [31:0]         timer;
  logic [31:0]         io_rdata;
  logic                led_we;
  logic                tmr_we;
  logic                swev_clr;

  assign io_hit     = (addr[31:10] == IO_BASE[31:10]);
  assign io_sel     = io_hit ? decode_offset(addr[9:0]) : IO_SEL_NONE;
  assign dmem_write = mem_write & ~io_hit;

  assign led_we   = mem_write && (io_sel == IO_SEL_LED);
  assign tmr_we   = mem_write && (io_sel == IO_SEL_TMR);
  assign swev_clr = mem_read  && (io_sel == IO_SEL_SWEV);

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
    switch_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .raw    (switch_in[i]),
      .stable (sw_stable[i]),
      .changed(sw_changed[i])
    );
  end

  always_comb begin
    io_rdata = '0;
    case (io_sel)
      IO_SEL_LED:  io_rdata = ISA_WIDTH'(led);
      IO_SEL_SW:   io_rdata = ISA_WIDTH'(sw_stable);
      IO_SEL_SWEV: io_rdata = ISA_WIDTH'(sw_event);
      IO_SEL_TMR:  io_rdata = timer;
      default:     io_rdata = '0;
    endcase
  end

  assign read_data = io_hit ? io_rdata : dmem_rdata;

  // Loads see pre-edge state, so a combined load/store returns the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led      <= '0;
      timer    <= '0;
      sw_event <= '0;
    end else begin
      if (led_we) begin
        led <= write_data[LED_WIDTH-1:0];
      end
      if (tmr_we) begin
        timer <= write_data;
      end else begin
        timer <= timer + 32'd1;
      end
      // A fresh update in the clearing cycle survives the clear.
      sw_event <= (sw_event & ~{SW_WIDTH{swev_clr}}) | sw_changed;
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - directed self-checking bench for mmio_bridge with a load scoreboard
module tb_mmio_bridge;

  localparam logic [31:0] A_LED  = 32'hFFFF_FC60;
  localparam logic [31:0] A_SW   = 32'hFFFF_FC70;
  localparam logic [31:0] A_SWEV = 32'hFFFF_FC74;
  localparam logic [31:0] A_TMR  = 32'hFFFF_FC80;
  localparam logic [31:0] A_UNM  = 32'hFFFF_FC90;
  localparam logic [31:0] DMEM_V = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] write_data;
  logic [31:0] dmem_rdata;
  logic        dmem_write;
  logic [31:0] read_data;
  logic [7:0]  switch_in;
  logic [7:0]  led;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  mmio_bridge #(
    .IO_BASE        (32'hFFFF_FC00),
    .DEBOUNCE_CYCLES(4),
    .SW_WIDTH       (8),
    .LED_WIDTH      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .write_data(write_data),
    .dmem_rdata(dmem_rdata),
    .dmem_write(dmem_write),
    .read_data (read_data),
    .switch_in (switch_in),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a load for one cycle; the expected word goes through the scoreboard.
  task automatic load(input logic [31:0] a, input logic [31:0] exp, input string tag);
    exp_t e;
    addr      = a;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    exp_q.push_back('{tag, exp});
    #1;
    e = exp_q.pop_front();
    check(e.tag, read_data, e.val);
    @(negedge clk);
    mem_read = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic exp_dw, input string tag);
    addr       = a;
    write_data = d;
    mem_write  = 1'b1;
    mem_read   = 1'b0;
    #1;
    check(tag, {31'd0, dmem_write}, {31'd0, exp_dw});
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    addr       = 32'h0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    write_data = 32'h0;
    dmem_rdata = DMEM_V;
    switch_in  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and mid-run reset
    check("led_reset", {24'd0, led}, 32'h0);
    load(A_SW,   32'h0, "sw_reset");
    load(A_SWEV, 32'h0, "swev_reset");
    store(A_LED, 32'hFF, 1'b0, "dw_led_ff");
    switch_in = 8'h81;
    repeat (7) @(negedge clk);
    load(A_SW, 32'h81, "sw_pre_rst");
    rst       = 1'b1;
    switch_in = 8'h00;
    #1;
    check("led_async_rst", {24'd0, led}, 32'h0);
    load(A_TMR, 32'h0, "tmr_in_rst");
    store(A_LED, 32'h33, 1'b0, "dw_store_in_rst");
    check("led_no_write_in_rst", {24'd0, led}, 32'h0);
    rst = 1'b0;
    load(A_TMR,  32'h0, "tmr_after_rst");
    load(A_SW,   32'h0, "sw_after_rst");
    load(A_SWEV, 32'h0, "swev_after_rst");

    // LED store
    store(A_LED, 32'h0000_01A5, 1'b0, "dw_led_a5");
    check("led_a5", {24'd0, led}, 32'hA5);
    load(A_LED, 32'hA5, "led_read");

    // Debounce latency, events and glitch rejection
    switch_in = 8'h3C;
    repeat (5) @(negedge clk);
    load(A_SW,   32'h00, "sw_before_latency");
    load(A_SW,   32'h3C, "sw_at_latency");
    load(A_SWEV, 32'h3C, "swev_set");
    load(A_SWEV, 32'h00, "swev_cleared");
    switch_in = 8'h3D;
    repeat (3) @(negedge clk);
    switch_in = 8'h3C;
    repeat (8) @(negedge clk);
    load(A_SW,   32'h3C, "sw_glitch");
    load(A_SWEV, 32'h00, "swev_glitch");

    // Update coincides with clearing load
    switch_in = 8'hBC;
    repeat (5) @(negedge clk);
    load(A_SWEV, 32'h00, "swev_coincide_pre");
    load(A_SWEV, 32'h80, "swev_coincide_kept");
    load(A_SWEV, 32'h00, "swev_coincide_clr");
    load(A_SW,   32'hBC, "sw_bc");

    // Timer load and wrap
    store(A_TMR, 32'hFFFF_FFFE, 1'b0, "dw_tmr");
    load(A_TMR, 32'hFFFF_FFFE, "tmr_loaded");
    load(A_TMR, 32'hFFFF_FFFF, "tmr_plus1");
    load(A_TMR, 32'h0000_0000, "tmr_wrap");

    // Combined load and store returns the old value
    addr       = A_LED;
    write_data = 32'h5A;
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    exp_q.push_back('{"led_rw_old", 32'hA5});
    #1;
    begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.tag, read_data, e.val);
    end
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check("led_rw_new", {24'd0, led}, 32'h5A);

    // Data_mem pass-through and unmapped I/O
    store(32'h0000_0010, 32'h1234, 1'b1, "dw_dmem");
    load(32'h0000_0010, DMEM_V, "dmem_read");
    store(32'h0000_0060, 32'h77, 1'b1, "dw_low_alias");
    store(32'hFFFF_F860, 32'h77, 1'b1, "dw_below_window");
    load(32'hFFFF_F860, DMEM_V, "below_window_read");
    store(A_UNM, 32'hFFFF_FFFF, 1'b0, "dw_unmapped");
    load(A_UNM, 32'h0, "unmapped_read");
    check("led_unchanged", {24'd0, led}, 32'h5A);
    load(A_SWEV, 32'h0, "swev_unchanged");
    load(A_SW,   32'hBC, "sw_unchanged");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
